data_mem_responder: RTL and testbench

Single-port data-memory responder on the load/store side of the sequential RISC-V core. It services the mem_read/mem_write requests raised by the decode/control logic for ld/sd doubleword accesses. Each access has a fixed, parameterised wait-state latency, followed by a one-cycle ready pulse. Misaligned, out-of-range and conflicting requests are rejected with an error flag and leave memory untouched.

---
 rtl/data_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Doubleword data-memory responder for the load/store path of the sequential core.
// Accepts one ld/sd request at a time. The access completes with a one-cycle ready
// pulse LATENCY cycles after acceptance, or is rejected with err=1 and causes no side
// effects.
module data_mem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          bad_q, bad_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic [63:0]   mem [DEPTH];

    // Request decode straight from the inputs, used only at acceptance.
    logic          req;
    logic          in_bad;
    logic [AW-1:0] in_idx;

    // Description of the access that commits on this edge, if any.
    logic          commit;
    logic          c_wr;
    logic          c_bad;
    logic [AW-1:0] c_idx;
    logic [63:0]   c_wdata;
    logic          mem_we;

    assign req    = mem_read | mem_write;
    assign in_idx = addr[AW+2:3];
    assign in_bad = (mem_read & mem_write) | (addr[2:0] != 3'd0) | (addr[63:AW+3] != '0);

    // Next-state logic. With LATENCY=1 the accepting edge is also the commit edge,
    // so the commit then uses the live inputs rather than the latched copy.
    always_comb begin
        // NOTE: every signal gets a default first so that no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        commit  = 1'b0;
        c_wr    = wr_q;
        c_bad   = bad_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = mem_write;
                    bad_d   = in_bad;
                    idx_d   = in_idx;
                    wdata_d = wdata;
                    cnt_d   = CW'(LATENCY - 1);
                    busy_d  = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                        c_wr    = mem_write;
                        c_bad   = in_bad;
                        c_idx   = in_idx;
                        c_wdata = wdata;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (commit) begin
            ready_d = 1'b1;
            err_d   = c_bad;
            if (!c_bad && !c_wr) begin
                rdata_d = mem[c_idx];
            end
        end
    end

    // A write is suppressed when reset is asserted on the commit edge.
    assign mem_we = commit & c_wr & ~c_bad & rst_n;

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents survive rst_n, and leaving it unreset keeps it mappable to RAM.
        if (mem_we) begin
            mem[c_idx] <= c_wdata;
        end
    end

    // FSM state, latched request and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Three instances are built with
// LATENCY = 1, 2 and 4. Each access is checked against a transaction-level model:
// an array per instance, the expected latency, and the error rules.
module tb_data_mem_responder;
    localparam int DEPTH = 128;
    localparam int NDUT  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_s    [NDUT];
    logic        wr_s    [NDUT];
    logic [63:0] addr_s  [NDUT];
    logic [63:0] wdata_s [NDUT];
    logic [63:0] rdata_s [NDUT];
    logic        ready_s [NDUT];
    logic        err_s   [NDUT];
    logic        busy_s  [NDUT];

    int total = 0;
    int bad   = 0;

    logic [63:0] ref_mem   [NDUT][DEPTH];
    logic [63:0] ref_rdata [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH  (DEPTH),
            .LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .mem_read (rd_s[g]),
            .mem_write(wr_s[g]),
            .addr     (addr_s[g]),
            .wdata    (wdata_s[g]),
            .rdata    (rdata_s[g]),
            .ready    (ready_s[g]),
            .err      (err_s[g]),
            .busy     (busy_s[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete access, starting in an IDLE cycle just after a rising edge.
    // Returns one cycle after the ready pulse, with the responder idle again.
    task automatic access(input int d, input logic r, input logic w,
                          input logic [63:0] a, input logic [63:0] wd, input bit perturb);
        int n;
        bit exp_err;
        exp_err = (r && w) || (a % 8 != 0) || (a >= 64'(DEPTH * 8));
        if (!exp_err) begin
            if (w) ref_mem[d][int'(a >> 3)] = wd;
            else   ref_rdata[d] = ref_mem[d][int'(a >> 3)];
        end
        rd_s[d]    = r;
        wr_s[d]    = w;
        addr_s[d]  = a;
        wdata_s[d] = wd;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (perturb && n == 1) begin
                addr_s[d]  = {$urandom, $urandom};
                wdata_s[d] = {$urandom, $urandom};
            end
            if (!ready_s[d]) check($sformatf("busy_wait d%0d", d), 64'(busy_s[d]), 64'd1);
        end while (!ready_s[d] && n < 16);
        check($sformatf("latency d%0d a=%0h", d, a), 64'(n), 64'(lat_of(d)));
        check($sformatf("err d%0d a=%0h", d, a), 64'(err_s[d]), 64'(exp_err));
        check($sformatf("busy_ready d%0d", d), 64'(busy_s[d]), 64'd1);
        check($sformatf("rdata d%0d a=%0h", d, a), rdata_s[d], ref_rdata[d]);
        rd_s[d] = 1'b0;
        wr_s[d] = 1'b0;
        @(posedge clk); #1;
        check($sformatf("ready_drop d%0d", d), 64'(ready_s[d]), 64'd0);
        check($sformatf("busy_drop d%0d", d), 64'(busy_s[d]), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            rd_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
            ref_rdata[d] = '0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_rdata d%0d", d), rdata_s[d], 64'd0);
            check($sformatf("rst_ready d%0d", d), 64'(ready_s[d]), 64'd0);
            check($sformatf("rst_err d%0d", d), 64'(err_s[d]), 64'd0);
            check($sformatf("rst_busy d%0d", d), 64'(busy_s[d]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill every location of every instance so later loads have known data.
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < DEPTH; i++)
                access(d, 1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom}, 1'b0);

        // Store then load back (LATENCY=2).
        access(1, 1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 1'b0);
        access(1, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0);
        check("raw_0x10", rdata_s[1], 64'hDEADBEEF_CAFEF00D);

        // Latency sweep: loads at address 0 on LATENCY=1 and LATENCY=4.
        access(0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
        access(2, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);

        // Error cases: misaligned store, out-of-range load, read and write together.
        access(1, 1'b0, 1'b1, 64'h13, 64'h1234_5678, 1'b0);
        access(1, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0);
        check("misaligned_no_write", rdata_s[1], 64'hDEADBEEF_CAFEF00D);
        access(1, 1'b1, 1'b0, 64'h400, 64'h0, 1'b0);
        access(1, 1'b1, 1'b1, 64'h18, 64'h5555, 1'b0);
        access(1, 1'b1, 1'b0, 64'h18, 64'h0, 1'b0);

        // Input isolation: addr/wdata change while the store is in flight.
        access(1, 1'b0, 1'b1, 64'h08, 64'h1111, 1'b1);
        access(1, 1'b1, 1'b0, 64'h08, 64'h0, 1'b0);
        check("isolation_mem1", rdata_s[1], 64'h1111);
        access(1, 1'b1, 1'b0, 64'h18, 64'h0, 1'b0);

        // Reset while a store is waiting: no ready, outputs cleared, no write.
        rd_s[1] = 1'b0; wr_s[1] = 1'b1; addr_s[1] = 64'h20; wdata_s[1] = 64'hAAAA;
        @(posedge clk); #1;
        check("midrst_accepted", 64'(busy_s[1]), 64'd1);
        rst_n   = 1'b0;
        wr_s[1] = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < NDUT; d++) begin
            ref_rdata[d] = '0;
            check($sformatf("midrst_rdata d%0d", d), rdata_s[d], 64'd0);
            check($sformatf("midrst_ready d%0d", d), 64'(ready_s[d]), 64'd0);
            check($sformatf("midrst_err d%0d", d), 64'(err_s[d]), 64'd0);
            check($sformatf("midrst_busy d%0d", d), 64'(busy_s[d]), 64'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("midrst_no_ready", 64'(ready_s[1]), 64'd0);
        end
        access(1, 1'b1, 1'b0, 64'h20, 64'h0, 1'b0);

        // Back-to-back: request held high, ready every LATENCY+1 cycles.
        rd_s[1] = 1'b1; wr_s[1] = 1'b0; addr_s[1] = 64'h08;
        ref_rdata[1] = ref_mem[1][1];
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_ready k%0d", k), 64'(ready_s[1]),
                  64'((k % (lat_of(1) + 1)) == lat_of(1)));
            if (ready_s[1]) check($sformatf("b2b_rdata k%0d", k), rdata_s[1], ref_rdata[1]);
        end
        rd_s[1] = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", 64'(busy_s[1]), 64'd0);

        // Random traffic across all instances.
        for (int t = 0; t < 300; t++) begin
            int d;
            int sel;
            logic r;
            logic w;
            logic [63:0] a;
            d   = int'($urandom_range(0, NDUT - 1));
            sel = int'($urandom_range(0, 9));
            a   = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
            r   = 1'($urandom_range(0, 1));
            w   = ~r;
            if (sel == 0) a = a | 64'($urandom_range(1, 7));
            if (sel == 1) a = 64'(DEPTH * 8) + 64'($urandom_range(0, 4095)) * 64'd8;
            if (sel == 2) a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            if (sel == 3) begin r = 1'b1; w = 1'b1; end
            access(d, r, w, a, {$urandom, $urandom}, bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
